// File: rtl/clkgen_rst_seq.sv
// clkgen_rst_seq: PLL-lock-qualified, staged multi-channel reset release sequencer
module clkgen_rst_seq #(
  parameter int NUM_CH      = 2,
  parameter int LOCK_FILT   = 1024,
  parameter int STAGE_DLY   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pll_locked_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              ready_o,
  output logic [1:0]        state_o,
  output logic [7:0]        lock_loss_cnt_o
);
  localparam int MAXV = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int CW   = $clog2(MAXV + 1);
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, RELEASE = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d, ext_sync_q, ext_sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]      rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lcnt_q, lcnt_d;
  logic                   locked_s, ext_ok_s, fault;
  assign locked_s        = lock_sync_q[SYNC_STAGES-1];
  assign ext_ok_s        = ext_sync_q[SYNC_STAGES-1];
  assign fault           = !locked_s || !ext_ok_s || sw_rst_req_i;
  assign rst_n_o         = rst_n_q;
  assign ready_o         = ready_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = lcnt_q;
  // One shared counter serves as lock filter, stage spacer and hold timer since those phases never overlap
  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_ni};
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_n_d     = rst_n_q;
    ready_d     = ready_q;
    lcnt_d      = lcnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (fault) cnt_d = '0;
        else if (cnt_q == CW'(LOCK_FILT - 1)) begin
          cnt_d   = '0;
          rst_n_d = NUM_CH'(1);
          ready_d = (NUM_CH == 1);
          state_d = (NUM_CH == 1) ? RUN : RELEASE;
        end else cnt_d = cnt_q + CW'(1);
      end
      RELEASE, RUN: begin
        if (fault) begin
          cnt_d   = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
          state_d = HOLD;
          if (!locked_s && lcnt_q != 8'hff) lcnt_d = lcnt_q + 8'd1;
        end else if (state_q == RELEASE) begin
          if (cnt_q == CW'(STAGE_DLY - 1)) begin
            cnt_d   = '0;
            rst_n_d = (rst_n_q << 1) | NUM_CH'(1);
            ready_d = rst_n_d[NUM_CH-1];
            state_d = rst_n_d[NUM_CH-1] ? RUN : RELEASE;
          end else cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (fault) cnt_d = '0;
        else if (cnt_q == CW'(STAGE_DLY - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else cnt_d = cnt_q + CW'(1);
      end
    endcase
  end
  // State, counters, synchronisers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_LOCK;
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
      cnt_q       <= '0;
      rst_n_q     <= '0;
      ready_q     <= 1'b0;
      lcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= lock_sync_d;
      ext_sync_q  <= ext_sync_d;
      cnt_q       <= cnt_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      lcnt_q      <= lcnt_d;
    end
  end
endmodule

// File: tb/tb_clkgen_rst_seq.sv
// tb_clkgen_rst_seq: directed checks of release timing, glitch filter, faults, saturation and reset
module tb_clkgen_rst_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1, pll = 1'b0, ext = 1'b0, sw = 1'b0;
  logic [2:0] rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lcnt;
  logic [0:0] rst_n1;
  logic       ready1;
  logic [1:0] state1;
  logic [7:0] lcnt1;
  int checks = 0, fails = 0;

  clkgen_rst_seq #(.NUM_CH(3), .LOCK_FILT(8), .STAGE_DLY(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .ext_rst_ni(ext), .sw_rst_req_i(sw),
    .rst_n_o(rst_n), .ready_o(ready), .state_o(state), .lock_loss_cnt_o(lcnt));

  clkgen_rst_seq #(.NUM_CH(1), .LOCK_FILT(8), .STAGE_DLY(4), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .ext_rst_ni(ext), .sw_rst_req_i(sw),
    .rst_n_o(rst_n1), .ready_o(ready1), .state_o(state1), .lock_loss_cnt_o(lcnt1));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(3);
    checks++; if ({rst_n, ready, state, lcnt} !== 14'd0) begin fails++; $display("FAIL reset_out got=%h exp=0", {rst_n, ready, state, lcnt}); end
    checks++; if ({rst_n1, ready1, state1, lcnt1} !== 12'd0) begin fails++; $display("FAIL reset_out1 got=%h exp=0", {rst_n1, ready1, state1, lcnt1}); end
  endtask

  task automatic test_powerup;
    rst = 1'b0; pll = 1'b1; ext = 1'b1;
    step(9);
    checks++; if (rst_n !== 3'b000 || state !== 2'd0) begin fails++; $display("FAIL pu_e9 rst_n=%b state=%0d exp 000/0", rst_n, state); end
    checks++; if (ready1 !== 1'b0 || rst_n1 !== 1'b0) begin fails++; $display("FAIL pu1_e9 ready=%b rst_n=%b exp 0/0", ready1, rst_n1); end
    step(1);
    checks++; if (rst_n !== 3'b001 || state !== 2'd1 || ready !== 1'b0) begin fails++; $display("FAIL pu_e10 rst_n=%b state=%0d ready=%b exp 001/1/0", rst_n, state, ready); end
    checks++; if (ready1 !== 1'b1 || rst_n1 !== 1'b1 || state1 !== 2'd2) begin fails++; $display("FAIL pu1_e10 ready=%b rst_n=%b state=%0d exp 1/1/2", ready1, rst_n1, state1); end
    step(3);
    checks++; if (rst_n !== 3'b001) begin fails++; $display("FAIL pu_e13 rst_n=%b exp 001", rst_n); end
    step(1);
    checks++; if (rst_n !== 3'b011 || state !== 2'd1) begin fails++; $display("FAIL pu_e14 rst_n=%b state=%0d exp 011/1", rst_n, state); end
    step(3);
    checks++; if (rst_n !== 3'b011 || ready !== 1'b0) begin fails++; $display("FAIL pu_e17 rst_n=%b ready=%b exp 011/0", rst_n, ready); end
    step(1);
    checks++; if (rst_n !== 3'b111 || ready !== 1'b1 || state !== 2'd2) begin fails++; $display("FAIL pu_e18 rst_n=%b ready=%b state=%0d exp 111/1/2", rst_n, ready, state); end
  endtask

  task automatic test_lock_loss_run;
    pll = 1'b0;
    step(1);
    pll = 1'b1;
    step(1);
    checks++; if (rst_n !== 3'b111 || state !== 2'd2) begin fails++; $display("FAIL ll_q2 rst_n=%b state=%0d exp 111/2", rst_n, state); end
    step(1);
    checks++; if (rst_n !== 3'b000 || state !== 2'd3 || ready !== 1'b0 || lcnt !== 8'd1) begin fails++; $display("FAIL ll_q3 rst_n=%b state=%0d ready=%b lcnt=%0d exp 000/3/0/1", rst_n, state, ready, lcnt); end
    checks++; if (rst_n1 !== 1'b0 || lcnt1 !== 8'd1) begin fails++; $display("FAIL ll1_q3 rst_n=%b lcnt=%0d exp 0/1", rst_n1, lcnt1); end
    step(3);
    checks++; if (state !== 2'd3) begin fails++; $display("FAIL ll_hold_end state=%0d exp 3", state); end
    step(1);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL ll_wait state=%0d exp 0", state); end
    step(7);
    checks++; if (state !== 2'd0 || rst_n !== 3'b000) begin fails++; $display("FAIL ll_q14 state=%0d rst_n=%b exp 0/000", state, rst_n); end
    step(1);
    checks++; if (state !== 2'd1 || rst_n !== 3'b001) begin fails++; $display("FAIL ll_q15 state=%0d rst_n=%b exp 1/001", state, rst_n); end
    step(8);
    checks++; if (state !== 2'd2 || rst_n !== 3'b111 || ready !== 1'b1 || lcnt !== 8'd1) begin fails++; $display("FAIL ll_q23 state=%0d rst_n=%b ready=%b lcnt=%0d exp 2/111/1/1", state, rst_n, ready, lcnt); end
  endtask

  task automatic test_glitch;
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    checks++; if (state !== 2'd3 || rst_n !== 3'b000 || lcnt !== 8'd1) begin fails++; $display("FAIL gl_sw state=%0d rst_n=%b lcnt=%0d exp 3/000/1", state, rst_n, lcnt); end
    step(4);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL gl_wait state=%0d exp 0", state); end
    step(3);
    pll = 1'b0;
    step(1);
    pll = 1'b1;
    step(4);
    checks++; if (state !== 2'd0 || rst_n !== 3'b000) begin fails++; $display("FAIL gl_s13 state=%0d rst_n=%b exp 0/000", state, rst_n); end
    step(5);
    checks++; if (state !== 2'd0 || rst_n !== 3'b000) begin fails++; $display("FAIL gl_s18 state=%0d rst_n=%b exp 0/000", state, rst_n); end
    step(1);
    checks++; if (state !== 2'd1 || rst_n !== 3'b001 || lcnt !== 8'd1) begin fails++; $display("FAIL gl_s19 state=%0d rst_n=%b lcnt=%0d exp 1/001/1", state, rst_n, lcnt); end
    checks++; if (ready1 !== 1'b1 || rst_n1 !== 1'b1) begin fails++; $display("FAIL gl1_s19 ready=%b rst_n=%b exp 1/1", ready1, rst_n1); end
  endtask

  task automatic test_sw_release;
    step(5);
    checks++; if (state !== 2'd1 || rst_n !== 3'b011) begin fails++; $display("FAIL sw_pre state=%0d rst_n=%b exp 1/011", state, rst_n); end
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    checks++; if (state !== 2'd3 || rst_n !== 3'b000 || lcnt !== 8'd1) begin fails++; $display("FAIL sw_hold state=%0d rst_n=%b lcnt=%0d exp 3/000/1", state, rst_n, lcnt); end
    step(4);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL sw_wait state=%0d exp 0", state); end
    step(8);
    checks++; if (state !== 2'd1 || rst_n !== 3'b001) begin fails++; $display("FAIL sw_rel state=%0d rst_n=%b exp 1/001", state, rst_n); end
    step(8);
    checks++; if (state !== 2'd2 || rst_n !== 3'b111 || ready !== 1'b1 || lcnt !== 8'd1 || lcnt1 !== 8'd1) begin fails++; $display("FAIL sw_run state=%0d rst_n=%b ready=%b lcnt=%0d lcnt1=%0d exp 2/111/1/1/1", state, rst_n, ready, lcnt, lcnt1); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      pll = 1'b0;
      step(1);
      pll = 1'b1;
      step(15);
      if (i == 99) begin
        checks++; if (lcnt !== 8'd101 || lcnt1 !== 8'd101) begin fails++; $display("FAIL sat_100 lcnt=%0d lcnt1=%0d exp 101", lcnt, lcnt1); end
      end
    end
    checks++; if (lcnt !== 8'd255 || lcnt1 !== 8'd255) begin fails++; $display("FAIL sat_300 lcnt=%0d lcnt1=%0d exp 255", lcnt, lcnt1); end
    checks++; if (state !== 2'd1 || rst_n !== 3'b001) begin fails++; $display("FAIL sat_state state=%0d rst_n=%b exp 1/001", state, rst_n); end
  endtask

  task automatic test_rst_run;
    step(8);
    checks++; if (state !== 2'd2 || rst_n !== 3'b111 || ready !== 1'b1) begin fails++; $display("FAIL rr_pre state=%0d rst_n=%b ready=%b exp 2/111/1", state, rst_n, ready); end
    rst = 1'b1;
    step(1);
    checks++; if ({rst_n, ready, state, lcnt} !== 14'd0) begin fails++; $display("FAIL rr_clear got=%h exp 0", {rst_n, ready, state, lcnt}); end
    checks++; if ({rst_n1, ready1, state1, lcnt1} !== 12'd0) begin fails++; $display("FAIL rr_clear1 got=%h exp 0", {rst_n1, ready1, state1, lcnt1}); end
    step(1);
    rst = 1'b0;
    step(1);
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL rr_wait state=%0d exp 0", state); end
    step(8);
    checks++; if (state !== 2'd0 || rst_n !== 3'b000) begin fails++; $display("FAIL rr_e9 state=%0d rst_n=%b exp 0/000", state, rst_n); end
    step(1);
    checks++; if (state !== 2'd1 || rst_n !== 3'b001 || lcnt !== 8'd0) begin fails++; $display("FAIL rr_e10 state=%0d rst_n=%b lcnt=%0d exp 1/001/0", state, rst_n, lcnt); end
    checks++; if (rst_n1 !== 1'b1 || ready1 !== 1'b1) begin fails++; $display("FAIL rr1_e10 rst_n=%b ready=%b exp 1/1", rst_n1, ready1); end
  endtask

  initial begin
    test_reset;
    test_powerup;
    test_lock_loss_run;
    test_glitch;
    test_sw_release;
    test_saturation;
    test_rst_run;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/clkgen_rst_seq.md
CLKGEN_RST_SEQ -- requirements
Module: clkgen_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of sequenced reset channels, legal range 1..8.
REQ-002 SHALL have parameter LOCK_FILT, default 1024: number of consecutive qualified-lock cycles required before release, legal range 1..65535.
REQ-003 SHALL have parameter STAGE_DLY, default 16: spacing in cycles between channel releases, and the minimum hold time after a fault; legal range 1..65535.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: flop depth of the input synchronisers, legal range 2..4.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: PLL lock, asynchronous to clk_i.
REQ-008 SHALL have port ext_rst_ni, input, 1 bit: external active-low reset request, asynchronous.
REQ-009 SHALL have port sw_rst_req_i, input, 1 bit: synchronous reset request, single-cycle pulse or level.
REQ-010 SHALL have port rst_n_o, output, NUM_CH bits: per-channel active-low resets, all registered.
REQ-011 SHALL have port ready_o, output, 1 bit: all channels released.
REQ-012 SHALL have port state_o, output, 2 bits: current FSM state encoding.
REQ-013 SHALL have port lock_loss_cnt_o, output, 8 bits: count of lock-loss faults.

Function
REQ-014 SHALL pass pll_locked_i and ext_rst_ni each through a SYNC_STAGES-deep flop chain; the chain outputs are locked_s and ext_ok_s.
REQ-015 SHALL define fault as the OR of: locked_s==0, ext_ok_s==0, or sw_rst_req_i==1.
REQ-016 SHALL implement FSM states WAIT_LOCK=0, RELEASE=1, RUN=2, HOLD=3, and drive state_o with the current state.
REQ-017 In WAIT_LOCK, the filter counter SHALL increment on each no-fault cycle and clear to 0 on any fault cycle; a single-cycle glitch therefore restarts the count.
REQ-018 The edge at which the filter counter equals LOCK_FILT-1 with no fault SHALL move the FSM to RELEASE, set rst_n_o[0]=1 and clear the stage counter.
REQ-019 In RELEASE, rst_n_o[k] SHALL rise exactly STAGE_DLY cycles after rst_n_o[k-1], for k=1..NUM_CH-1.
REQ-020 Released channels SHALL stay high until a fault occurs.
REQ-021 The edge that sets rst_n_o[NUM_CH-1] SHALL also set ready_o=1 and move the FSM to RUN.
REQ-022 If NUM_CH==1, the FSM SHALL pass through RELEASE for zero cycles: WAIT_LOCK goes directly to RUN, with rst_n_o[0] and ready_o rising on the same edge.
REQ-023 A fault in RELEASE or RUN SHALL, at the next edge, clear all rst_n_o bits, clear ready_o, load the hold counter and move the FSM to HOLD.
REQ-024 HOLD SHALL last STAGE_DLY cycles, then move to WAIT_LOCK with the filter counter at 0.
REQ-025 Any fault during HOLD SHALL reload the hold counter.
REQ-026 In WAIT_LOCK and HOLD, all rst_n_o bits SHALL be 0 and ready_o SHALL be 0.
REQ-027 lock_loss_cnt_o SHALL increment by 1 on each RELEASE/RUN-to-HOLD transition in which locked_s==0, including when sw or ext faults occur simultaneously.
REQ-028 lock_loss_cnt_o SHALL saturate at 255.
REQ-029 lock_loss_cnt_o SHALL be cleared only by rst_i.
REQ-030 On simultaneous fault and filter-count completion, the fault SHALL win: the FSM stays in WAIT_LOCK with the count cleared.
REQ-031 All internal counters SHALL be wide enough for max(LOCK_FILT, STAGE_DLY) without wrap-around.

Reset
REQ-032 rst_i SHALL have priority over all other inputs.
REQ-033 rst_i SHALL force at the next edge: FSM=WAIT_LOCK, rst_n_o=0, ready_o=0, lock_loss_cnt_o=0, all counters=0, synchroniser flops=0.
REQ-034 rst_i asserted mid-RELEASE or mid-RUN SHALL take effect identically, with no lock-loss increment.
REQ-035 After rst_i deasserts, the FSM SHALL enter WAIT_LOCK directly, without passing through HOLD.

Verification (NUM_CH=3, LOCK_FILT=8, STAGE_DLY=4, SYNC_STAGES=2 unless noted)
REQ-036 Power-up: rst_i released; pll_locked_i and ext_rst_ni high from edge E -> rst_n_o[0] rises at E+10, rst_n_o[1] at E+14, rst_n_o[2] and ready_o at E+18, state_o 0->1->2.
REQ-037 Lock glitch: pll_locked_i low for 1 cycle at filter count 5 in WAIT_LOCK -> release is delayed; full 8 further qualified cycles are required.
REQ-038 Lock loss in RUN: pll_locked_i low for 1 cycle -> all rst_n_o=0 and state_o=3 two edges after sync; HOLD lasts 4 cycles, then WAIT_LOCK; lock_loss_cnt_o=1; full sequence repeats.
REQ-039 sw_rst_req_i pulse in RELEASE after ch1 released -> all channels drop, HOLD, re-release; lock_loss_cnt_o unchanged.
REQ-040 300 lock-loss events -> lock_loss_cnt_o reads 255.
REQ-041 rst_i asserted in RUN -> all outputs 0 next edge, lock_loss_cnt_o=0; NUM_CH=1 run shows ready_o and rst_n_o[0] rising together.
